snn_delay_layer: RTL
====================

SNN_DELAY_LAYER -- requirements
Module: snn_delay_layer

Interface
REQ-001 SHALL have parameter N_IN, default 8, number of input spike channels.
REQ-002 SHALL have parameter N_OUT, default 2, number of LIF neurons.
REQ-003 SHALL have parameter W_BITS, default 8, signed synaptic weight width.
REQ-004 SHALL have parameter V_BITS, default 12, signed membrane/threshold width; also cfg_wdata width.
REQ-005 SHALL have parameter DELAY_MAX, default 8, power of two; per-input delay range 0..DELAY_MAX-1.
REQ-006 SHALL have parameter LEAK_SHIFT, default 3, arithmetic-right-shift leak factor.
REQ-007 SHALL have parameter THRESH_DEFAULT, default 150, threshold value after reset.
REQ-008 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1, synchronous, active-high.
REQ-010 SHALL have port step_in, input, 1, one-cycle time-step request.
REQ-011 SHALL have port input_spikes, input, N_IN, spikes sampled on an accepted step.
REQ-012 SHALL have port cfg_we, input, 1, configuration write strobe.
REQ-013 SHALL have port cfg_addr, input, A_BITS = clog2(N_IN*N_OUT+N_IN+1), configuration address.
REQ-014 SHALL have port cfg_wdata, input, V_BITS, configuration data.
REQ-015 SHALL have port output_spikes, output, N_OUT, registered spikes of the last completed step.
REQ-016 SHALL have port data_valid_out, output, 1, one-cycle pulse on step completion.
REQ-017 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-018 SHALL have port overrun, output, 1, sticky flag for a step_in dropped while busy.
REQ-019 SHALL have port cfg_err, output, 1, one-cycle pulse for a rejected configuration write.

Function
REQ-020 Address map SHALL be: weight[i][j] at i*N_OUT+j (low W_BITS of cfg_wdata); delay[i] at N_IN*N_OUT+i (low clog2(DELAY_MAX) bits); threshold at N_IN*N_OUT+N_IN.
REQ-021 A write SHALL be rejected, with cfg_err pulsed the next cycle, if it arrives while busy=1 or targets an address above the threshold address.
REQ-022 FSM SHALL have states IDLE, ACCUM, FIRE, DONE.
REQ-023 In IDLE, step_in=1 SHALL shift input_spikes into each input's DELAY_MAX-deep history (hist[i][0] = newest) and move to ACCUM with input index 0.
REQ-024 In ACCUM, one input per cycle for N_IN cycles: if hist[i][delay[i]]=1, sign-extended weight[i][j] SHALL be added to membrane v[j] for all j in parallel, saturating at V_BITS signed limits.
REQ-025 In FIRE (1 cycle), per neuron: if v[j] >= threshold (signed), spike[j]=1 and v[j]=0; else spike[j]=0 and v[j] = v[j] - (v[j] >>> LEAK_SHIFT).
REQ-026 In DONE (1 cycle), output_spikes SHALL be loaded, data_valid_out SHALL pulse, and the FSM SHALL return to IDLE.
REQ-027 Latency: step accepted in cycle T SHALL produce data_valid_out in cycle T+N_IN+2; output_spikes SHALL hold until the next DONE.
REQ-028 A step_in while busy SHALL be ignored, leaving history, membranes and outputs untouched, and SHALL set overrun.
REQ-029 A step_in in the DONE cycle SHALL count as busy.
REQ-030 Delay 0 SHALL select the spike sampled in the current step.

Reset
REQ-031 Reset SHALL set state IDLE, all histories 0, all membranes 0, all weights 0, all delays 0, threshold THRESH_DEFAULT, output_spikes 0, data_valid_out 0, busy 0, overrun 0, cfg_err 0.
REQ-032 Reset mid-step SHALL abort the step with no data_valid_out pulse.
REQ-033 Reset SHALL take priority over step_in and cfg_we in the same cycle.

Structure
REQ-034 Package snn_pkg SHALL hold the FSM state enum and the address-region base calculations.
REQ-035 One sub-module, snn_delay_line (one per input, depth DELAY_MAX, tap select), SHALL be instantiated N_IN times.

Verification
REQ-036 Leak/fire case, defaults, w[0][0]=100, thr=150, delay[0]=0, input0 spike two consecutive steps -> step1 spikes=00 (v0 leaks to 88); step2 spikes[0]=1 and v0=0.
REQ-037 Delay case, w[1][1]=200, delay[1]=3, input1 spike at step0 only -> output_spikes[1]=0 at steps 0-2 and 1 at step3.
REQ-038 Positive saturation, all w[i][0]=127, thr=2047, all inputs spiking every step -> v0 is 889 after step1 and 1667 after step2; step3 saturates at 2047 and spikes.
REQ-039 Negative saturation, all w[i][0]=-128, all inputs spiking -> v0 clamps to -2048, then leaks to -1792, with no spike.
REQ-040 Handshake/error, step_in during ACCUM plus cfg write during ACCUM -> overrun=1, cfg_err pulses, exactly one data_valid_out pulse at T+10.
REQ-041 Reset asserted in FIRE -> no data_valid_out, all outputs 0, threshold back to 150.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and address-map helpers for the delayed-spike LIF layer.
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIRE  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Weights occupy addresses 0 .. n_in*n_out-1, then one delay per input, then the threshold.
  function automatic int delay_base(input int n_in, input int n_out);
    return n_in * n_out;
  endfunction

  function automatic int thresh_addr(input int n_in, input int n_out);
    return n_in * n_out + n_in;
  endfunction

  function automatic int addr_bits(input int n_in, input int n_out);
    return $clog2(thresh_addr(n_in, n_out) + 1);
  endfunction

endpackage

// File: rtl/snn_delay_layer_if.sv
// Step/spike handshake and configuration bus of the delayed-spike LIF layer.
// Outputs are registered in the layer; step_in while busy is dropped and flagged, never stalled.
interface snn_delay_layer_if
  import snn_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int N_OUT  = 2,
  parameter int V_BITS = 12,
  parameter int A_BITS = addr_bits(N_IN, N_OUT)
);
  logic              step_in;
  logic [N_IN-1:0]   input_spikes;
  logic              cfg_we;
  logic [A_BITS-1:0] cfg_addr;
  logic [V_BITS-1:0] cfg_wdata;
  logic [N_OUT-1:0]  output_spikes;
  logic              data_valid_out;
  logic              busy;
  logic              overrun;
  logic              cfg_err;

  modport master (
    output step_in, input_spikes, cfg_we, cfg_addr, cfg_wdata,
    input  output_spikes, data_valid_out, busy, overrun, cfg_err
  );

  modport slave (
    input  step_in, input_spikes, cfg_we, cfg_addr, cfg_wdata,
    output output_spikes, data_valid_out, busy, overrun, cfg_err
  );
endinterface

// File: rtl/snn_delay_line.sv
// Per-input spike history shift register with a selectable tap; 0-cycle tap read.
// Shifts only when shift_en is high; tap 0 is the most recently shifted-in spike.
module snn_delay_line #(
  parameter int DELAY_MAX = 8,
  localparam int D_BITS = $clog2(DELAY_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              spike_in,
  input  logic [D_BITS-1:0] tap_sel,
  output logic              tap_out
);

  logic [DELAY_MAX-1:0] hist_q;
  logic [DELAY_MAX-1:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (shift_en) begin
      hist_d = {hist_q[DELAY_MAX-2:0], spike_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign tap_out = hist_q[tap_sel];

endmodule

// File: rtl/snn_delay_layer.sv
// Delayed-spike integrate/leak/fire layer: step accepted at T gives data_valid_out at T+N_IN+2.
// No backpressure: step_in while busy is dropped and sets sticky overrun; config writes while busy are rejected.
module snn_delay_layer
  import snn_pkg::*;
#(
  parameter int N_IN           = 8,
  parameter int N_OUT          = 2,
  parameter int W_BITS         = 8,
  parameter int V_BITS         = 12,
  parameter int DELAY_MAX      = 8,
  parameter int LEAK_SHIFT     = 3,
  parameter int THRESH_DEFAULT = 150
) (
  input  logic               clk,
  input  logic               reset,
  snn_delay_layer_if.slave   bus
);

  localparam int D_BITS = $clog2(DELAY_MAX);
  localparam int A_BITS = addr_bits(N_IN, N_OUT);
  localparam int I_BITS = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [A_BITS-1:0] DLY_BASE = A_BITS'(delay_base(N_IN, N_OUT));
  localparam logic [A_BITS-1:0] THR_ADDR = A_BITS'(thresh_addr(N_IN, N_OUT));
  localparam logic signed [V_BITS-1:0] V_MAX = {1'b0, {(V_BITS-1){1'b1}}};
  localparam logic signed [V_BITS-1:0] V_MIN = {1'b1, {(V_BITS-1){1'b0}}};

  state_e                    state_q, state_d;
  logic [I_BITS-1:0]         idx_q, idx_d;
  logic signed [V_BITS-1:0]  v_q [N_OUT];
  logic signed [V_BITS-1:0]  v_d [N_OUT];
  logic signed [W_BITS-1:0]  w_q [N_IN][N_OUT];
  logic signed [W_BITS-1:0]  w_d [N_IN][N_OUT];
  logic [D_BITS-1:0]         dly_q [N_IN];
  logic [D_BITS-1:0]         dly_d [N_IN];
  logic signed [V_BITS-1:0]  thr_q, thr_d;
  logic [N_OUT-1:0]          out_spk_q, out_spk_d;
  logic                      dv_q, dv_d;
  logic                      overrun_q, overrun_d;
  logic                      cfg_err_q, cfg_err_d;
  logic [N_IN-1:0]           taps;
  logic                      busy;
  logic                      shift_en;

  assign busy     = (state_q != IDLE);
  assign shift_en = (state_q == IDLE) && bus.step_in;

  for (genvar i = 0; i < N_IN; i++) begin : g_dl
    snn_delay_line #(.DELAY_MAX(DELAY_MAX)) u_delay_line (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .spike_in (bus.input_spikes[i]),
      .tap_sel  (dly_q[i]),
      .tap_out  (taps[i])
    );
  end

  // Sign-extended weight add with clamping to the membrane's signed range.
  function automatic logic signed [V_BITS-1:0] sat_add(
    input logic signed [V_BITS-1:0] a,
    input logic signed [W_BITS-1:0] b
  );
    logic signed [V_BITS:0] s;
    s = (V_BITS+1)'(a) + (V_BITS+1)'(b);
    if (s[V_BITS] != s[V_BITS-1]) begin
      return s[V_BITS] ? V_MIN : V_MAX;
    end
    return s[V_BITS-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    v_d       = v_q;
    w_d       = w_q;
    dly_d     = dly_q;
    thr_d     = thr_q;
    out_spk_d = out_spk_q;
    dv_d      = 1'b0;
    overrun_d = overrun_q | (bus.step_in & busy);
    cfg_err_d = 1'b0;

    if (bus.cfg_we) begin
      if (busy || (bus.cfg_addr > THR_ADDR)) begin
        cfg_err_d = 1'b1;
      end else begin
        for (int i = 0; i < N_IN; i++) begin
          for (int j = 0; j < N_OUT; j++) begin
            if (bus.cfg_addr == A_BITS'(i*N_OUT + j)) begin
              w_d[i][j] = bus.cfg_wdata[W_BITS-1:0];
            end
          end
          if (bus.cfg_addr == DLY_BASE + A_BITS'(i)) begin
            dly_d[i] = bus.cfg_wdata[D_BITS-1:0];
          end
        end
        if (bus.cfg_addr == THR_ADDR) begin
          thr_d = bus.cfg_wdata;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.step_in) begin
          state_d = ACCUM;
          idx_d   = '0;
        end
      end
      ACCUM: begin
        if (taps[idx_q]) begin
          for (int j = 0; j < N_OUT; j++) begin
            v_d[j] = sat_add(v_q[j], w_q[idx_q][j]);
          end
        end
        if (idx_q == I_BITS'(N_IN - 1)) begin
          state_d = FIRE;
        end else begin
          idx_d = idx_q + I_BITS'(1);
        end
      end
      FIRE: begin
        // Spikes land in the output register here so they are visible alongside the DONE pulse.
        for (int j = 0; j < N_OUT; j++) begin
          if (v_q[j] >= thr_q) begin
            out_spk_d[j] = 1'b1;
            v_d[j]       = '0;
          end else begin
            out_spk_d[j] = 1'b0;
            v_d[j]       = v_q[j] - (v_q[j] >>> LEAK_SHIFT);
          end
        end
        dv_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      v_q       <= '{default: '0};
      w_q       <= '{default: '0};
      dly_q     <= '{default: '0};
      thr_q     <= V_BITS'(THRESH_DEFAULT);
      out_spk_q <= '0;
      dv_q      <= 1'b0;
      overrun_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      v_q       <= v_d;
      w_q       <= w_d;
      dly_q     <= dly_d;
      thr_q     <= thr_d;
      out_spk_q <= out_spk_d;
      dv_q      <= dv_d;
      overrun_q <= overrun_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.output_spikes  = out_spk_q;
  assign bus.data_valid_out = dv_q;
  assign bus.busy           = busy;
  assign bus.overrun        = overrun_q;
  assign bus.cfg_err        = cfg_err_q;

endmodule
